// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port, variable-latency memory between the fetch (i_*) and load/store (d_*) ports.
// Latency: request in cycle 0 -> mem_req in cycle 1 -> ack in the cycle after mem_ready (2 cycles minimum).
// Backpressure: each requester holds its req until its one-cycle ack; the memory stretches with mem_ready=0.
// Ports:
//   clk, reset         clock; asynchronous active-low reset
//   i_req/i_addr       fetch request and address; i_cancel abandons a pending or in-flight fetch
//   i_rdata/i_ack      registered fetch data and its one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata   data request (store when d_we=1)
//   d_rdata/d_ack      registered load data and its one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata   latched memory request, held until mem_ready
//   mem_rdata/mem_ready                 memory response
//   busy               a memory transaction is in flight
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int ISTARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_cancel,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] SCNT_MAX = 4'(ISTARVE_MAX);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_scnt;
  logic       r_cancel;
  logic       w_i_elig;
  logic       w_d_elig;
  logic       w_grant_i;
  logic       w_grant_d;
  logic       w_done;

  // A port whose ack is high this cycle is finishing, not requesting again;
  // this lets the other port take the memory in the ack cycle.
  assign w_i_elig = i_req & ~i_ack & ~i_cancel;
  assign w_d_elig = d_req & ~d_ack;
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Data wins contention unless fetch has already lost SCNT_MAX times in a row.
        if (w_i_elig && (!w_d_elig || (r_scnt == SCNT_MAX))) begin
          w_grant_i    = 1'b1;
          w_next_state = S_BUSY_I;
        end else if (w_d_elig) begin
          w_grant_d    = 1'b1;
          w_next_state = S_BUSY_D;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (mem_ready) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_rdata   <= '0;
      i_ack     <= 1'b0;
      d_rdata   <= '0;
      d_ack     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r_scnt    <= 4'd0;
      r_cancel  <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;

      if (w_grant_i) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= i_addr;
        r_scnt   <= 4'd0;
      end else if (w_grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        // Only count data wins that actually made a fetch wait.
        if (i_req && (r_scnt != SCNT_MAX)) begin
          r_scnt <= r_scnt + 4'd1;
        end
      end else if (w_done) begin
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        r_cancel <= 1'b0;
        if (r_state == S_BUSY_D) begin
          d_ack <= 1'b1;
          if (!mem_we) begin
            d_rdata <= mem_rdata;
          end
        end else if (!r_cancel && !i_cancel) begin
          // A cancel seen at any point of the fetch, including this last
          // cycle, discards the response; the memory access still completes.
          i_ack   <= 1'b1;
          i_rdata <= mem_rdata;
        end
      end else if ((r_state == S_BUSY_I) && i_cancel) begin
        r_cancel <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  localparam int P_BUSY    = 0;
  localparam int P_MEMREQ  = 1;
  localparam int P_MEMWE   = 2;
  localparam int P_IACK    = 3;
  localparam int P_DACK    = 4;
  localparam int P_IRDATA  = 5;
  localparam int P_DRDATA  = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_cancel, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          i_ack, d_ack;
  logic          mem_req, mem_we, mem_ready, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .ISTARVE_MAX(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  // Memory model: fixed contents per address, ready after 'lat' cycles of mem_req.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'hDEAD_BEEF;
      32'h0000_0080: return 32'h3333_4444;
      32'h0000_0100: return 32'hCAFE_F00D;
      32'h0000_0200: return 32'h1111_2222;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  int   lat = 1;
  int   r_wait;
  logic spurious = 1'b0;
  int   cyc = 0;
  logic done = 1'b0;

  assign mem_rdata = mem_val(mem_addr);
  assign mem_ready = spurious | (mem_req && (r_wait >= lat - 1));

  always @(posedge clk or negedge reset) begin
    if (!reset)                   r_wait <= 0;
    else if (mem_req && !mem_ready) r_wait <= r_wait + 1;
    else                          r_wait <= 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic port_i; logic [31:0] data; } ack_t;
  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; logic chkw; } grant_t;
  typedef struct { int cyc; int sig; logic [31:0] val; } probe_t;

  ack_t   ackq[$];
  grant_t grantq[$];
  probe_t probeq[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares grants, acks and cycle probes against the expectation queues.
  initial begin
    logic   prev_req;
    grant_t cur;
    grant_t g;
    ack_t   a;
    probe_t p;
    logic [31:0] act;
    string  nm;
    prev_req = 1'b0;
    cur = '{0, 1'b0, 32'h0, 32'h0, 1'b0};
    forever begin
      @(negedge clk);
      if (done) begin
        chk("pending_acks", 32'(ackq.size()), 32'd0);
        chk("pending_grants", 32'(grantq.size()), 32'd0);
        chk("pending_probes", 32'(probeq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      if (!reset) begin
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_i_ack", 32'(i_ack), 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        prev_req = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          if (grantq.size() == 0) begin
            chk("unexpected_grant", 32'(mem_req), 32'd0);
          end else begin
            g = grantq.pop_front();
            chk("grant_cycle", 32'(cyc), 32'(g.cyc));
            chk("grant_we", 32'(mem_we), 32'(g.we));
            chk("grant_addr", mem_addr, g.addr);
            if (g.chkw) chk("grant_wdata", mem_wdata, g.wdata);
            chk("grant_busy", 32'(busy), 32'd1);
            cur = g;
          end
        end else if (mem_req) begin
          chk("hold_addr", mem_addr, cur.addr);
          chk("hold_we", 32'(mem_we), 32'(cur.we));
          if (cur.chkw) chk("hold_wdata", mem_wdata, cur.wdata);
        end
        prev_req = mem_req;
        if (i_ack || d_ack) begin
          if (ackq.size() == 0) begin
            chk("unexpected_ack", 32'({i_ack, d_ack}), 32'd0);
          end else begin
            a = ackq.pop_front();
            chk("ack_cycle", 32'(cyc), 32'(a.cyc));
            chk("ack_i", 32'(i_ack), 32'(a.port_i));
            chk("ack_d", 32'(d_ack), 32'(!a.port_i));
            chk("ack_data", a.port_i ? i_rdata : d_rdata, a.data);
          end
        end
      end
      while (probeq.size() > 0 && probeq[0].cyc <= cyc) begin
        p = probeq.pop_front();
        if (p.cyc != cyc) begin
          chk("probe_late", 32'(cyc), 32'(p.cyc));
        end else begin
          case (p.sig)
            P_BUSY:   begin act = 32'(busy);    nm = "probe_busy";    end
            P_MEMREQ: begin act = 32'(mem_req); nm = "probe_mem_req"; end
            P_MEMWE:  begin act = 32'(mem_we);  nm = "probe_mem_we";  end
            P_IACK:   begin act = 32'(i_ack);   nm = "probe_i_ack";   end
            P_DACK:   begin act = 32'(d_ack);   nm = "probe_d_ack";   end
            P_IRDATA: begin act = i_rdata;      nm = "probe_i_rdata"; end
            default:  begin act = d_rdata;      nm = "probe_d_rdata"; end
          endcase
          chk(nm, act, p.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic exp_grant(input int c, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic chkw);
    grantq.push_back('{c, we, addr, wdata, chkw});
  endtask

  task automatic exp_ack(input int c, input logic port_i, input logic [31:0] data);
    ackq.push_back('{c, port_i, data});
  endtask

  task automatic probe(input int c, input int sig, input logic [31:0] val);
    probeq.push_back('{c, sig, val});
  endtask

  initial begin
    int t;
    reset = 1'b0; i_req = 1'b0; i_cancel = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    ticks(3);
    reset = 1'b1;
    t = cyc;
    probe(t, P_BUSY, 0);
    probe(t, P_MEMREQ, 0);

    // Single load at minimum latency.
    tick(); t = cyc;
    d_req = 1'b1; d_addr = 32'h40;
    exp_grant(t + 1, 1'b0, 32'h40, 32'h0, 1'b1);
    exp_ack(t + 2, 1'b0, 32'hDEAD_BEEF);
    probe(t + 2, P_MEMREQ, 0);
    probe(t + 2, P_BUSY, 0);
    probe(t + 3, P_DACK, 0);
    probe(t + 3, P_DRDATA, 32'hDEAD_BEEF);
    ticks(3); d_req = 1'b0;

    // Contention: grants alternate D, I, D, I through the ack cycles.
    tick(); t = cyc;
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h80;
    exp_grant(t + 1, 1'b0, 32'h80, 32'h0, 1'b1);   exp_ack(t + 2, 1'b0, 32'h3333_4444);
    exp_grant(t + 3, 1'b0, 32'h100, 32'h0, 1'b0);  exp_ack(t + 4, 1'b1, 32'hCAFE_F00D);
    exp_grant(t + 5, 1'b0, 32'h200, 32'h0, 1'b1);  exp_ack(t + 6, 1'b0, 32'h1111_2222);
    exp_grant(t + 7, 1'b0, 32'h100, 32'h0, 1'b0);  exp_ack(t + 8, 1'b1, 32'hCAFE_F00D);
    probe(t + 9, P_BUSY, 0);
    ticks(3); d_addr = 32'h200;
    ticks(4); d_req = 1'b0;
    ticks(2); i_req = 1'b0;

    // Starvation bound (limit 2) at 3-cycle latency; fetch held off by i_cancel.
    tick(); t = cyc;
    lat = 3;
    i_req = 1'b1; i_addr = 32'h300; i_cancel = 1'b1; d_req = 1'b1; d_addr = 32'h40;
    exp_grant(t + 1,  1'b0, 32'h40,  32'h0, 1'b1); exp_ack(t + 4,  1'b0, 32'hDEAD_BEEF);
    exp_grant(t + 6,  1'b0, 32'h80,  32'h0, 1'b1); exp_ack(t + 9,  1'b0, 32'h3333_4444);
    exp_grant(t + 11, 1'b0, 32'h300, 32'h0, 1'b0); exp_ack(t + 14, 1'b1, 32'h5A5A_0300);
    exp_grant(t + 15, 1'b0, 32'h200, 32'h0, 1'b1); exp_ack(t + 18, 1'b0, 32'h1111_2222);
    exp_grant(t + 20, 1'b0, 32'h40,  32'h0, 1'b1); exp_ack(t + 23, 1'b0, 32'hDEAD_BEEF);
    exp_grant(t + 24, 1'b0, 32'h300, 32'h0, 1'b0); exp_ack(t + 27, 1'b1, 32'h5A5A_0300);
    ticks(4);  d_addr = 32'h80;
    ticks(6);  i_cancel = 1'b0; d_addr = 32'h200;
    ticks(5);  i_cancel = 1'b1; d_addr = 32'h40;
    ticks(4);  i_cancel = 1'b0;
    ticks(1);  d_req = 1'b0;
    ticks(8);  i_req = 1'b0;

    // Store with four wait states; d_rdata keeps the last load value.
    tick(); t = cyc;
    lat = 5;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h1234_5678;
    exp_grant(t + 1, 1'b1, 32'h44, 32'h1234_5678, 1'b1);
    exp_ack(t + 6, 1'b0, 32'hDEAD_BEEF);
    probe(t + 6, P_MEMREQ, 0);
    probe(t + 6, P_MEMWE, 0);
    probe(t + 7, P_DRDATA, 32'hDEAD_BEEF);
    ticks(7); d_req = 1'b0; d_we = 1'b0; d_wdata = '0;

    // Cancel during a 2-cycle fetch, then a normal fetch.
    tick(); t = cyc;
    lat = 2;
    i_req = 1'b1; i_addr = 32'h200;
    exp_grant(t + 1, 1'b0, 32'h200, 32'h0, 1'b0);
    probe(t + 3, P_BUSY, 0);
    probe(t + 3, P_IACK, 0);
    probe(t + 3, P_IRDATA, 32'h5A5A_0300);
    exp_grant(t + 5, 1'b0, 32'h100, 32'h0, 1'b0);
    exp_ack(t + 7, 1'b1, 32'hCAFE_F00D);
    tick(); i_cancel = 1'b1; i_req = 1'b0;
    tick(); i_cancel = 1'b0;
    ticks(2); i_req = 1'b1; i_addr = 32'h100;
    ticks(4); i_req = 1'b0;

    // Cancel in the same cycle as mem_ready, then mem_ready with no request.
    tick(); t = cyc;
    lat = 1;
    i_req = 1'b1; i_addr = 32'h80;
    exp_grant(t + 1, 1'b0, 32'h80, 32'h0, 1'b0);
    probe(t + 2, P_BUSY, 0);
    probe(t + 2, P_IACK, 0);
    probe(t + 2, P_IRDATA, 32'hCAFE_F00D);
    probe(t + 3, P_BUSY, 0);
    probe(t + 3, P_IACK, 0);
    probe(t + 4, P_DACK, 0);
    probe(t + 4, P_MEMREQ, 0);
    tick(); i_cancel = 1'b1; i_req = 1'b0;
    tick(); i_cancel = 1'b0; spurious = 1'b1;
    ticks(3); spurious = 1'b0;

    // Reset in the middle of a stalled load, then a clean load.
    tick(); t = cyc;
    lat = 100;
    d_req = 1'b1; d_addr = 32'h40;
    exp_grant(t + 1, 1'b0, 32'h40, 32'h0, 1'b1);
    ticks(2); reset = 1'b0; d_req = 1'b0;
    ticks(2); reset = 1'b1; lat = 1;
    probe(t + 4, P_BUSY, 0);
    probe(t + 4, P_MEMREQ, 0);
    probe(t + 4, P_DRDATA, 32'h0);
    tick(); d_req = 1'b1; d_addr = 32'h80;
    exp_grant(t + 6, 1'b0, 32'h80, 32'h0, 1'b1);
    exp_ack(t + 7, 1'b0, 32'h3333_4444);
    ticks(3); d_req = 1'b0;

    ticks(3);
    done = 1'b1;
  end

endmodule
